// File: rtl/config_pkg.sv
// Shared definitions for the column configuration chain loader:
// state encoding and the default configuration word width.
package config_pkg;

    localparam int CFG_WORD_W = 32;

    localparam logic [1:0] CFG_IDLE = 2'd0;
    localparam logic [1:0] CFG_LOAD = 2'd1;
    localparam logic [1:0] CFG_SET  = 2'd2;
    localparam logic [1:0] CFG_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = CFG_IDLE,
        ST_LOAD = CFG_LOAD,
        ST_SET  = CFG_SET,
        ST_DONE = CFG_DONE
    } cfg_state_t;

endpackage

// File: rtl/config_word_serializer.sv
// One-word LSB-first serializer. When empty, a load paired with a shift passes
// bit 0 straight through so an accepted word costs no bubble.
module config_word_serializer #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 11,
    parameter int BW     = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [WORD_W-1:0] i_data,
    input  logic [CNT_W-1:0]  i_need,
    output logic              o_bit,
    output logic              o_empty,
    output logic              o_last,
    output logic [BW-1:0]     o_cnt_nxt
);

    logic [WORD_W-1:0] r_buf, w_buf_nxt;
    logic [BW-1:0]     r_cnt, w_nbits;

    // A final partial word only contributes the bits the chain still needs.
    assign w_nbits = (32'(i_need) >= 32'(WORD_W)) ? BW'(WORD_W) : BW'(i_need);

    assign o_bit   = (r_cnt == '0) ? i_data[0] : r_buf[0];
    assign o_empty = (r_cnt == '0);
    assign o_last  = (r_cnt == BW'(1));

    always_comb begin
        w_buf_nxt = r_buf;
        o_cnt_nxt = r_cnt;
        if (i_clear) begin
            w_buf_nxt = '0;
            o_cnt_nxt = '0;
        end else if (i_shift) begin
            if (r_cnt == '0) begin
                if (i_load) begin
                    w_buf_nxt = i_data >> 1;
                    o_cnt_nxt = w_nbits - BW'(1);
                end
            end else if (r_cnt == BW'(1)) begin
                if (i_load) begin
                    w_buf_nxt = i_data;
                    o_cnt_nxt = w_nbits;
                end else begin
                    o_cnt_nxt = '0;
                end
            end else begin
                w_buf_nxt = r_buf >> 1;
                o_cnt_nxt = r_cnt - BW'(1);
            end
        end else if (i_load) begin
            w_buf_nxt = i_data;
            o_cnt_nxt = w_nbits;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else begin
            r_buf <= w_buf_nxt;
            r_cnt <= o_cnt_nxt;
        end
    end

endmodule

// File: rtl/config_chain_loader.sv
// Streams configuration words into a column shift chain, then pulses the
// tile set line. Every output is a flop computed from next-state values.
module config_chain_loader
    import config_pkg::*;
#(
    parameter int WORD_W    = CFG_WORD_W,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              shift_out,
    output logic              cfg_cen,
    output logic              set_out,
    output logic              busy,
    output logic              done
);

    localparam int               BW  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);

    cfg_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_bits_sent, w_sent_nxt, w_need, w_rem_nxt;
    logic             r_in_ready, r_shift_out, r_cfg_cen, r_set_out, r_busy, r_done;
    logic             w_accept, w_shift, w_clear, w_enter_load, w_ready_nxt;
    logic             w_ser_bit, w_ser_empty, w_ser_last;
    logic [BW-1:0]    w_ser_cnt_nxt;

    // Words are only taken when the buffer is empty or draining its last bit.
    assign w_accept = r_in_ready && in_valid && (w_ser_empty || w_ser_last);
    assign w_shift  = (r_state == ST_LOAD) && (!w_ser_empty || w_accept);
    assign w_sent_nxt = r_bits_sent + CNT_W'(w_shift);
    assign w_need     = LEN - r_bits_sent - CNT_W'(w_ser_last);
    assign w_rem_nxt  = LEN - w_sent_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_LOAD;
            ST_LOAD:          if (r_bits_sent == LEN) w_state_nxt = ST_SET;
            ST_SET:           w_state_nxt = ST_DONE;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_enter_load = (r_state != ST_LOAD) && (w_state_nxt == ST_LOAD);
    assign w_clear      = w_enter_load || (r_state == ST_LOAD && w_state_nxt == ST_SET);
    assign w_ready_nxt  = (w_state_nxt == ST_LOAD) &&
                          (w_enter_load ||
                           ((32'(w_rem_nxt) > 32'(w_ser_cnt_nxt)) && (w_ser_cnt_nxt <= BW'(1))));

    config_word_serializer #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W),
        .BW     (BW)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_load    (w_accept),
        .i_shift   (w_shift),
        .i_data    (in_data),
        .i_need    (w_need),
        .o_bit     (w_ser_bit),
        .o_empty   (w_ser_empty),
        .o_last    (w_ser_last),
        .o_cnt_nxt (w_ser_cnt_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_bits_sent <= '0;
            r_in_ready  <= 1'b0;
            r_shift_out <= 1'b0;
            r_cfg_cen   <= 1'b0;
            r_set_out   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bits_sent <= w_enter_load ? '0 : w_sent_nxt;
            r_in_ready  <= w_ready_nxt;
            if (w_shift) r_shift_out <= w_ser_bit;
            r_cfg_cen   <= w_shift;
            r_set_out   <= (w_state_nxt == ST_SET);
            r_busy      <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_SET);
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    assign in_ready  = r_in_ready;
    assign shift_out = r_shift_out;
    assign cfg_cen   = r_cfg_cen;
    assign set_out   = r_set_out;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench: a 40-bit chain (index 0) and a 64-bit chain (index 1).
module tb_config_chain_loader;

    logic        clk, rst;
    logic [1:0]  st, vld;
    logic [31:0] dat [2];
    wire  [1:0]  rdy, so, cen, setp, bsy, dn;

    config_chain_loader #(.WORD_W(32), .CHAIN_LEN(40)) u_dut40 (
        .clk(clk), .rst(rst), .start(st[0]), .in_data(dat[0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .shift_out(so[0]), .cfg_cen(cen[0]), .set_out(setp[0]),
        .busy(bsy[0]), .done(dn[0]));

    config_chain_loader #(.WORD_W(32), .CHAIN_LEN(64)) u_dut64 (
        .clk(clk), .rst(rst), .start(st[1]), .in_data(dat[1]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .shift_out(so[1]), .cfg_cen(cen[1]), .set_out(setp[1]),
        .busy(bsy[1]), .done(dn[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          low;       // in_ready-high cycles with in_valid held low before w1
        logic [63:0] exp_bits;
        int          exp_gaps;  // cfg_cen-low cycles inside the load
    } vec_t;

    vec_t vt [4];

    int          checks, errors, cyc;
    logic [1:0]  rdy_s, acc, arm, xtra, pen, last_bit;
    logic [63:0] cap [2];
    int ncen[2], first[2], gaps[2], hold_err[2], nset[2], set_cyc[2];
    int done_cyc[2], start_cyc[2], xacc[2], pa[2], pb[2];

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic sample();
        cyc++;
        for (int d = 0; d < 2; d++) begin
            rdy_s[d] = rdy[d];
            acc[d]   = rdy[d] && vld[d];
            if (xtra[d] && acc[d]) xacc[d]++;
            if (cen[d]) begin
                if (ncen[d] < 64) cap[d][ncen[d]] = so[d];
                ncen[d]++;
                if (first[d] < 0) first[d] = cyc;
                last_bit[d] = so[d];
            end else if (bsy[d] && !setp[d] && first[d] >= 0) begin
                gaps[d]++;
                if (so[d] !== last_bit[d]) hold_err[d]++;
            end
            if (setp[d]) begin
                nset[d]++;
                set_cyc[d] = cyc;
            end
            if (arm[d] && dn[d] && done_cyc[d] < 0) done_cyc[d] = cyc;
            if (pen[d]) st[d] = (cyc == pa[d]) || (cyc == pb[d]);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic clear(input int d);
        ncen[d] = 0; cap[d] = '0; first[d] = -1; gaps[d] = 0; hold_err[d] = 0;
        nset[d] = 0; set_cyc[d] = -1; done_cyc[d] = -1; xacc[d] = 0;
        last_bit[d] = 1'b0; arm[d] = 1'b0; xtra[d] = 1'b0; pen[d] = 1'b0;
    endtask

    task automatic do_start(input int d);
        st[d] = 1'b1;
        tick();
        st[d] = 1'b0;
        start_cyc[d] = cyc;
        arm[d] = 1'b1;
    endtask

    task automatic send(input int d, input logic [31:0] w, input int low);
        int n;
        bit ok;
        n = 0;
        vld[d] = 1'b0;
        for (int t = 0; t < 200 && n < low; t++) begin
            tick();
            if (rdy_s[d]) n++;
        end
        dat[d] = w;
        vld[d] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            tick();
            ok = acc[d];
        end
        vld[d] = 1'b0;
        if (!ok) chk("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic run(input int d, input vec_t v, input bit extra, input bit pulse);
        int          L;
        logic [63:0] mask;
        L    = (d == 0) ? 40 : 64;
        mask = (L == 64) ? '1 : ((64'd1 << L) - 64'd1);
        clear(d);
        do_start(d);
        chk("start_state", 64'({dn[d], bsy[d], rdy[d]}), 64'(3'b011));
        if (pulse) begin
            pa[d]  = start_cyc[d] + 10;
            pb[d]  = start_cyc[d] + L + 2;
            pen[d] = 1'b1;
        end
        send(d, v.w0, 0);
        send(d, v.w1, v.low);
        if (extra) begin
            xtra[d] = 1'b1;
            dat[d]  = 32'hFFFF_FFFF;
            vld[d]  = 1'b1;
        end
        for (int t = 0; t < 300 && done_cyc[d] < 0; t++) tick();
        if (done_cyc[d] < 0) chk("done_timeout", 64'(0), 64'(1));
        repeat (3) tick();
        vld[d] = 1'b0;
        pen[d] = 1'b0;
        st[d]  = 1'b0;
        chk("cen_count", 64'(ncen[d]), 64'(L));
        chk("bits", cap[d] & mask, v.exp_bits & mask);
        chk("gaps", 64'(gaps[d]), 64'(v.exp_gaps));
        chk("hold", 64'(hold_err[d]), 64'(0));
        chk("set_count", 64'(nset[d]), 64'(1));
        chk("set_after_first", 64'(set_cyc[d] - first[d]), 64'(L + v.exp_gaps));
        chk("done_latency", 64'(done_cyc[d] - start_cyc[d]), 64'(L + 3 + v.exp_gaps));
        chk("done_level", 64'({dn[d], bsy[d], setp[d], cen[d], rdy[d]}), 64'(5'b10000));
        if (extra) chk("overrun_accepts", 64'(xacc[d]), 64'(0));
        xtra[d] = 1'b0;
    endtask

    initial begin
        vec_t basic, multi;
        vt[0] = '{32'h89AB_CDEF, 32'h0000_00A5, 0, 64'h00_0000_00A5_89AB_CDEF, 0};
        vt[1] = '{32'h89AB_CDEF, 32'h0000_00A5, 6, 64'h00_0000_00A5_89AB_CDEF, 5};
        vt[2] = '{32'h0F0F_0F0F, 32'hFFFF_FF3C, 0, 64'h00_0000_003C_0F0F_0F0F, 0};
        vt[3] = '{32'h1234_5678, 32'hABCD_EF01, 2, 64'h00_0000_0001_1234_5678, 1};
        basic = vt[0];
        multi = '{32'hDEAD_BEEF, 32'h1234_5678, 0, 64'h1234_5678_DEAD_BEEF, 0};

        checks = 0; errors = 0; cyc = 0;
        rst = 1'b0; st = '0; vld = '0; dat[0] = '0; dat[1] = '0;
        clear(0); clear(1);
        repeat (3) tick();
        chk("reset_outputs_40", 64'({rdy[0], so[0], cen[0], setp[0], bsy[0], dn[0]}), 64'(0));
        chk("reset_outputs_64", 64'({rdy[1], so[1], cen[1], setp[1], bsy[1], dn[1]}), 64'(0));
        rst = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run(0, vt[i], 1'b0, 1'b0);

        // Third word offered after the chain is full must never be taken.
        run(0, basic, 1'b1, 1'b0);

        // Reset partway through the first word.
        clear(0);
        do_start(0);
        send(0, 32'h89AB_CDEF, 0);
        for (int t = 0; t < 100 && ncen[0] < 17; t++) tick();
        chk("pre_reset_bits", 64'(ncen[0]), 64'(17));
        #2 rst = 1'b0;
        #1;
        chk("reset_async", 64'({rdy[0], so[0], cen[0], setp[0], bsy[0], dn[0]}), 64'(0));
        repeat (3) tick();
        chk("reset_no_set", 64'(nset[0]), 64'(0));
        chk("reset_held", 64'({rdy[0], so[0], cen[0], setp[0], bsy[0], dn[0]}), 64'(0));
        rst = 1'b1;
        tick();
        run(0, basic, 1'b0, 1'b0);

        // start pulses during LOAD and during SET must be ignored.
        run(0, basic, 1'b0, 1'b1);

        run(1, multi, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Configuration bitstream loader that sits directly upstream of the top tile of each fabric column. It accepts configuration words over a valid/ready stream, serializes exactly `CHAIN_LEN` bits into the tile shift chain via `shift_in_from_north`, then pulses `set_in_from_north` so every tile latches its shadow configuration. It also gates the chain shift enable so the chain advances only on cycles that carry a real bit.

## Interface
- `WORD_W`, 32: width of incoming configuration words.
- `CHAIN_LEN`, 1024: total bits in the column shift chain, ≥1.
- `CNT_W`, `$clog2(CHAIN_LEN+1)`: bit-counter width, derived.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin a load; sampled only in IDLE or DONE.
- `in_data` in `WORD_W`: configuration word.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: loader accepts word this cycle.
- `shift_out` out 1: to `shift_in_from_north` of the top tile.
- `cfg_cen` out 1: chain shift enable; high only when `shift_out` carries a valid bit.
- `set_out` out 1: to `set_in_from_north`; one-cycle pulse.
- `busy` out 1: high in LOAD and SET.
- `done` out 1: high in DONE.

## Operation
- Reset values: state IDLE; `in_ready`, `shift_out`, `cfg_cen`, `set_out`, `busy`, `done` all 0; bit counter 0; word buffer empty.
- States:
  - IDLE: `start` → LOAD.
  - LOAD: `bits_sent == CHAIN_LEN` → SET.
  - SET: one cycle, then DONE.
  - DONE: `start` → LOAD.
- `start` in LOAD or SET is ignored.
- Word buffer: one `WORD_W` shift register plus a remaining-bit count.
- Bits leave the buffer LSB first. The first bit shifted ends deepest in the chain.
- `in_ready` = LOAD && bits still needed > bits buffered && (buffer empty || last buffered bit shifts this cycle). This gives zero-bubble streaming when `in_valid` is held high.
- Shift cycle: in LOAD with a bit buffered, `shift_out` = buffer[0], `cfg_cen` = 1, `bits_sent` increments.
- No bit buffered (upstream stall): `cfg_cen` = 0 and `shift_out` holds its last value.
- Final word: only `CHAIN_LEN mod WORD_W` low bits are shifted (all bits if the remainder is 0). Upper bits are discarded, and the buffer is cleared on entry to SET.
- After `CHAIN_LEN` bits, `in_ready` stays 0; extra words are never accepted.
- `set_out` = 1 only in SET. `cfg_cen` = 0 in SET.
- A new `start` from DONE clears the counter and buffer; `done` drops the cycle LOAD is entered.

## Timing
- All outputs are registered.
- `start` at edge N → `busy` = 1 and `in_ready` = 1 (buffer empty) from N+1.
- Word accepted at edge M → its first bit on `shift_out` with `cfg_cen` = 1 in cycle M+1.
- Continuous `in_valid`: exactly `CHAIN_LEN` consecutive `cfg_cen` cycles.
- Last bit in cycle K → `set_out` = 1 in K+1 → `done` = 1 from K+2.
- Start-to-done latency with no stalls: `CHAIN_LEN` + 3 cycles.
- Reset asserted mid-LOAD or mid-SET: all outputs go to reset values immediately (asynchronous), no `set_out` pulse, partial chain contents are not committed.
- Simultaneous accept and last-bit shift: the new word's bit 0 follows in the next cycle with no gap.

## Structure
- Shared package/header `config_pkg`:
  - state encoding localparams `CFG_IDLE`, `CFG_LOAD`, `CFG_SET`, `CFG_DONE`;
  - default `WORD_W`.
- Sub-module `config_word_serializer`: word buffer, remaining-bit count, LSB-first shift, partial-last-word truncation. Interface: load/shift in; bit, empty, last-bit out.
- Top level holds the FSM, `bits_sent` counter and handshake logic.

## Test plan
- **Basic load** (`CHAIN_LEN`=40, `WORD_W`=32): words 0x89ABCDEF then 0x000000A5 streamed continuously.
  - `shift_out` over 40 cfg_cen cycles = 0x89ABCDEF LSB-first, then 0xA5 LSB-first.
  - `set_out` pulses once in cycle 41; `done` from cycle 42.
  - Second word's bits 8–31 ignored.
- **Upstream stall**: same data, `in_valid` low for 5 cycles between the two words.
  - `cfg_cen` low exactly 5 cycles; `shift_out` held; still 40 bits total.
  - Single `set_out` pulse.
- **Overrun guard**: third word 0xFFFFFFFF offered after bit 40.
  - `in_ready` never asserts; word not consumed.
  - Chain sees no extra `cfg_cen`.
- **Reset mid-load**: `rst` low after 17 bits.
  - All outputs 0 immediately; no `set_out` pulse.
  - Fresh `start` reloads all 40 bits correctly.
- **Start while busy**: `start` pulsed in LOAD and in SET → no effect; exactly one `set_out` pulse; `done` as in the basic-load case.
- **Exact multiple** (`CHAIN_LEN`=64): two words 0xDEADBEEF, 0x12345678 → all 64 bits shifted, `set_out` in cycle 65.
